// File: rtl/wb_pkg.sv
// Shared writeback definitions: default widths, write-entry layout and a clog2 helper.
// Optional forwarding lookup in the merge queue is enabled by defining WB_MERGE_FWD_EN.
package wb_pkg;

    localparam int WORD_WIDTH_DEF     = 16;
    localparam int REG_ADDR_WIDTH_DEF = 3;
    localparam int NUM_REGS_DEF       = 2 ** REG_ADDR_WIDTH_DEF;

    typedef struct packed {
        logic [REG_ADDR_WIDTH_DEF-1:0] addr;
        logic [WORD_WIDTH_DEF-1:0]     data;
    } wb_entry_t;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// Single producer-channel write FIFO; exposes the queued entries oldest-first.
// Entry data is only exported when WB_MERGE_FWD_EN is defined.
module wb_chan_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [AW-1:0]         push_addr,
    input  logic [DW-1:0]         push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [AW-1:0]         head_addr,
    output logic [DW-1:0]         head_data,
    output logic [DEPTH-1:0]      ent_vld,
    output logic [DEPTH*AW-1:0]   ent_addr
`ifdef WB_MERGE_FWD_EN
    ,
    output logic [DEPTH*DW-1:0]   ent_data
`endif
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // Index 0 is the oldest entry, DEPTH-1 the youngest slot.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        ent_vld  = '0;
        ent_addr = '0;
`ifdef WB_MERGE_FWD_EN
        ent_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx                   = rd_ptr + PW'(i);
            ent_vld[i]            = (CW'(i) < count);
            ent_addr[i*AW +: AW]  = mem_addr[idx];
`ifdef WB_MERGE_FWD_EN
            ent_data[i*DW +: DW]  = mem_data[idx];
`endif
        end
    end

endmodule

// File: rtl/wb_merge_queue.sv
// Writeback merge queue: per-channel FIFOs round-robin merged onto one register-file write port.
// Define WB_MERGE_FWD_EN to add the fwd_addr/fwd_hit/fwd_data bypass lookup.
module wb_merge_queue
    import wb_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int DEPTH          = 4,
    parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic                             gclk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                in_valid,
    output logic [NUM_CH-1:0]                in_ready,
    input  logic [NUM_CH*REG_ADDR_WIDTH-1:0] in_addr,
    input  logic [NUM_CH*WORD_WIDTH-1:0]     in_data,
    output logic                             RegWriteEnable,
    output logic [REG_ADDR_WIDTH-1:0]        RegWriteAddr,
    output logic [WORD_WIDTH-1:0]            RegWriteData,
    output logic [(2**REG_ADDR_WIDTH)-1:0]   pending_mask
`ifdef WB_MERGE_FWD_EN
    ,
    input  logic [REG_ADDR_WIDTH-1:0]        fwd_addr,
    output logic                             fwd_hit,
    output logic [WORD_WIDTH-1:0]            fwd_data
`endif
);

    localparam int RAW = REG_ADDR_WIDTH;
    localparam int WW  = WORD_WIDTH;
    localparam int CHW = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]      push;
    logic [NUM_CH-1:0]      grant;
    logic [NUM_CH-1:0]      full;
    logic [NUM_CH-1:0]      empty;
    logic [RAW-1:0]         head_addr [NUM_CH];
    logic [WW-1:0]          head_data [NUM_CH];
    logic [DEPTH-1:0]       ent_vld   [NUM_CH];
    logic [DEPTH*RAW-1:0]   ent_addr  [NUM_CH];
`ifdef WB_MERGE_FWD_EN
    logic [DEPTH*WW-1:0]    ent_data  [NUM_CH];
`endif

    logic [CHW-1:0]         rr_ptr;
    logic [CHW-1:0]         win;
    logic                   found;

    assign in_ready = ~full;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // R0 is hardwired zero, so those writes are accepted and dropped.
        assign push[c] = in_valid[c] & ~full[c] & (in_addr[c*RAW +: RAW] != '0);

        wb_chan_fifo #(
            .DEPTH (DEPTH),
            .AW    (RAW),
            .DW    (WW)
        ) u_fifo (
            .clk       (gclk),
            .rst       (rst),
            .push      (push[c]),
            .push_addr (in_addr[c*RAW +: RAW]),
            .push_data (in_data[c*WW +: WW]),
            .pop       (grant[c]),
            .full      (full[c]),
            .empty     (empty[c]),
            .head_addr (head_addr[c]),
            .head_data (head_data[c]),
            .ent_vld   (ent_vld[c]),
            .ent_addr  (ent_addr[c])
`ifdef WB_MERGE_FWD_EN
            ,
            .ent_data  (ent_data[c])
`endif
        );
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        int             idx;
        logic [CHW-1:0] sel;
        grant = '0;
        win   = rr_ptr;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            sel = CHW'(idx);
            if (!found && !empty[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                win        = sel;
            end
        end
    end

    // Stage p1: popped entry lands in the register-file write register.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            RegWriteEnable <= 1'b0;
            RegWriteAddr   <= '0;
            RegWriteData   <= '0;
            rr_ptr         <= CHW'(NUM_CH - 1);
        end else begin
            RegWriteEnable <= found;
            if (found) begin
                RegWriteAddr <= head_addr[win];
                RegWriteData <= head_data[win];
                rr_ptr       <= win;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld[c][i]) pending_mask[ent_addr[c][i*RAW +: RAW]] = 1'b1;
            end
        end
        if (RegWriteEnable) pending_mask[RegWriteAddr] = 1'b1;
    end

`ifdef WB_MERGE_FWD_EN
    // Later assignments win: output register < higher channel < lower channel; younger < older never.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_addr != '0) begin
            if (RegWriteEnable && (RegWriteAddr == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = RegWriteData;
            end
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_vld[c][i] && (ent_addr[c][i*RAW +: RAW] == fwd_addr)) begin
                        fwd_hit  = 1'b1;
                        fwd_data = ent_data[c][i*WW +: WW];
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_merge_queue.sv
// Randomised scoreboard bench for wb_merge_queue against a queue-based reference model.
// Forwarding checks are compiled in when WB_MERGE_FWD_EN is defined.
module tb_wb_merge_queue;

    localparam int NCH = 2;
    localparam int DEP = 4;

    logic        gclk = 1'b0;
    logic        rst  = 1'b1;
    logic [1:0]  in_valid = '0;
    logic [1:0]  in_ready;
    logic [5:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        RegWriteEnable;
    logic [2:0]  RegWriteAddr;
    logic [15:0] RegWriteData;
    logic [7:0]  pending_mask;
`ifdef WB_MERGE_FWD_EN
    logic [2:0]  fwd_addr = '0;
    logic        fwd_hit;
    logic [15:0] fwd_data;
`endif

    wb_merge_queue dut (
        .gclk           (gclk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_data        (in_data),
        .RegWriteEnable (RegWriteEnable),
        .RegWriteAddr   (RegWriteAddr),
        .RegWriteData   (RegWriteData),
        .pending_mask   (pending_mask)
`ifdef WB_MERGE_FWD_EN
        ,
        .fwd_addr       (fwd_addr),
        .fwd_hit        (fwd_hit),
        .fwd_data       (fwd_data)
`endif
    );

    always #5 gclk = ~gclk;

    int checks   = 0;
    int failures = 0;

    // Model state: entries are {addr[2:0], data[15:0]}
    logic [18:0] mq0[$];
    logic [18:0] mq1[$];
    logic [18:0] exp_q[$];
    int          rr;
    logic        m_we;
    logic [2:0]  m_addr;
    logic [15:0] m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int qsize(input int c);
        return (c == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [7:0] model_mask();
        logic [7:0] m;
        m = '0;
        foreach (mq0[i]) m[mq0[i][18:16]] = 1'b1;
        foreach (mq1[i]) m[mq1[i][18:16]] = 1'b1;
        if (m_we) m[m_addr] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        exp_q.delete();
        rr     = NCH - 1;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // One clock edge of the reference behaviour, evaluated from pre-edge state.
    task automatic model_edge();
        logic [1:0]  acc;
        int          winner;
        int          idx;
        logic [18:0] e;
        for (int c = 0; c < NCH; c++) acc[c] = in_valid[c] && (qsize(c) < DEP);
        winner = -1;
        for (int i = 1; i <= NCH; i++) begin
            idx = (rr + i) % NCH;
            if (winner < 0 && qsize(idx) > 0) winner = idx;
        end
        if (winner >= 0) begin
            e = (winner == 0) ? mq0.pop_front() : mq1.pop_front();
            exp_q.push_back(e);
            m_we   = 1'b1;
            m_addr = e[18:16];
            m_data = e[15:0];
            rr     = winner;
        end else begin
            m_we = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (acc[c] && in_addr[c*3 +: 3] != 3'd0) begin
                if (c == 0) mq0.push_back({in_addr[2:0], in_data[15:0]});
                else        mq1.push_back({in_addr[5:3], in_data[31:16]});
            end
        end
    endtask

    // Drive at the falling edge, check readiness, let one rising edge happen.
    task automatic step(input logic [1:0] v, input logic [5:0] a, input logic [31:0] d);
        logic [1:0] exp_rdy;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        #1;
        exp_rdy = {qsize(1) < DEP, qsize(0) < DEP};
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge gclk);
        if (!rst) model_edge();
        @(negedge gclk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_we", 32'(RegWriteEnable), 32'd0);
        check("rst_addr", 32'(RegWriteAddr), 32'd0);
        check("rst_data", 32'(RegWriteData), 32'd0);
        check("rst_pending", 32'(pending_mask), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd3);
        @(posedge gclk);
        @(negedge gclk);
        rst = 1'b0;
    endtask

    // Monitor: compares DUT outputs to the model shortly after every rising edge.
    initial begin
        logic [18:0] e;
`ifdef WB_MERGE_FWD_EN
        logic        f_hit;
        logic [15:0] f_data;
`endif
        forever begin
            @(posedge gclk);
            #2;
            check("we", 32'(RegWriteEnable), 32'(m_we));
            if (RegWriteEnable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual addr=%0h data=%0h required=none", RegWriteAddr, RegWriteData);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(RegWriteAddr), 32'(e[18:16]));
                    check("wr_data", 32'(RegWriteData), 32'(e[15:0]));
                end
            end else begin
                check("hold_addr", 32'(RegWriteAddr), 32'(m_addr));
                check("hold_data", 32'(RegWriteData), 32'(m_data));
            end
            check("pending", 32'(pending_mask), 32'(model_mask()));
`ifdef WB_MERGE_FWD_EN
            f_hit  = 1'b0;
            f_data = '0;
            if (fwd_addr != 3'd0) begin
                if (m_we && m_addr == fwd_addr) begin f_hit = 1'b1; f_data = m_data; end
                foreach (mq1[i]) if (mq1[i][18:16] == fwd_addr) begin f_hit = 1'b1; f_data = mq1[i][15:0]; end
                foreach (mq0[i]) if (mq0[i][18:16] == fwd_addr) begin f_hit = 1'b1; f_data = mq0[i][15:0]; end
            end
            check("fwd_hit", 32'(fwd_hit), 32'(f_hit));
            check("fwd_data", 32'(fwd_data), 32'(f_data));
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge gclk);
        @(negedge gclk);
        check("init_we", 32'(RegWriteEnable), 32'd0);
        check("init_pending", 32'(pending_mask), 32'd0);
        check("init_ready", 32'(in_ready), 32'd3);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step(2'b00, '0, '0);

        // Single write latency on channel 0
        step(2'b01, {3'd0, 3'd3}, {16'h0000, 16'hBEEF});
        check("lat_pending_e1", 32'(pending_mask[3]), 32'd1);
        check("lat_we_e1", 32'(RegWriteEnable), 32'd0);
        step(2'b00, '0, '0);
        check("lat_we_e2", 32'(RegWriteEnable), 32'd1);
        check("lat_addr_e2", 32'(RegWriteAddr), 32'd3);
        check("lat_data_e2", 32'(RegWriteData), 32'hBEEF);
        step(2'b00, '0, '0);
        check("lat_pending_e3", 32'(pending_mask[3]), 32'd0);

        // Full contention: both channels push every cycle
        for (int k = 0; k < 8; k++)
            step(2'b11, {3'((k + 3) % 7 + 1), 3'(k % 7 + 1)},
                 {16'(16'h1100 + k), 16'(16'h0A00 + k)});
        for (int k = 0; k < 12; k++) step(2'b00, '0, '0);

        // Write to R0 is swallowed
        step(2'b10, {3'd0, 3'd0}, {16'h1234, 16'h0000});
        check("r0_pending", 32'(pending_mask), 32'd0);
        step(2'b00, '0, '0);
        check("r0_we", 32'(RegWriteEnable), 32'd0);

        // Reset in the middle of a burst
        step(2'b01, {3'd0, 3'd2}, {16'h0, 16'h0222});
        step(2'b01, {3'd0, 3'd4}, {16'h0, 16'h0444});
        step(2'b01, {3'd0, 3'd6}, {16'h0, 16'h0666});
        do_reset();
        for (int k = 0; k < 4; k++) step(2'b00, '0, '0);

`ifdef WB_MERGE_FWD_EN
        step(2'b01, {3'd0, 3'd5}, {16'h0, 16'h0001});
        step(2'b01, {3'd0, 3'd5}, {16'h0, 16'h0002});
        in_valid = '0;
        fwd_addr = 3'd5;
        #1;
        check("fwd5_hit", 32'(fwd_hit), 32'd1);
        check("fwd5_data", 32'(fwd_data), 32'h0002);
        fwd_addr = 3'd0;
        #1;
        check("fwd0_hit", 32'(fwd_hit), 32'd0);
        check("fwd0_data", 32'(fwd_data), 32'd0);
        for (int k = 0; k < 4; k++) step(2'b00, '0, '0);
`endif

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
`ifdef WB_MERGE_FWD_EN
            fwd_addr = 3'($urandom);
`endif
            step(2'($urandom), 6'($urandom), $urandom);
            if (k == 250) do_reset();
        end
        for (int k = 0; k < 16; k++) step(2'b00, '0, '0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_merge_queue.md
Name: wb_merge_queue

Overview:
- Parametrised next-generation writeback stage.
- Accepts register-file writes from NUM_CH independent producer channels (e.g. ALU, memory, multiplier), buffers them in per-channel FIFOs, and round-robin arbitrates them onto the single register-file write port.
- Exports a per-register pending-write mask so issue logic can stall on write-after-write and read-after-write hazards.

Parameters:
NUM_CH, 2, number of producer channels (1..8)
DEPTH, 4, entries per channel FIFO (power of 2, >=2)
WORD_WIDTH, 16, data word width
REG_ADDR_WIDTH, 3, register address width; NUM_REGS = 2**REG_ADDR_WIDTH

Ports:
gclk  in  1  clock; all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  NUM_CH  per-channel write request
in_ready  out  NUM_CH  per-channel accept; high = FIFO not full
in_addr  in  NUM_CH*REG_ADDR_WIDTH  per-channel destination, channel c at [c*RAW +: RAW]
in_data  in  NUM_CH*WORD_WIDTH  per-channel data, channel c at [c*WW +: WW]
RegWriteEnable  out  1  register-file write strobe (registered)
RegWriteAddr  out  REG_ADDR_WIDTH  register-file write address (registered)
RegWriteData  out  WORD_WIDTH  register-file write data (registered)
pending_mask  out  NUM_REGS  bit r = a write to r is queued or on the output register

Behaviour:
- Reset: asynchronous and active-high, as already decided. While rst is high:
  - all FIFOs empty;
  - RegWriteEnable=0, RegWriteAddr=0, RegWriteData=0;
  - pending_mask=0;
  - in_ready=all ones;
  - round-robin pointer = NUM_CH-1, so channel 0 is granted first.
- Reset mid-operation discards all queued writes; no partial write is emitted.
- Accept: channel c accepts on an edge where in_valid[c] & in_ready[c].
  - in_ready[c] = !full[c]. It depends only on registered state; there is no same-cycle pop-through when full.
  - A write to address 0 is accepted but not enqueued, because R0 is hardwired zero.
- Arbitration: each cycle, at most one non-empty FIFO is popped.
  - Search starts at pointer+1 mod NUM_CH; the first non-empty channel wins; the pointer updates to the winner.
  - If all FIFOs are empty, there is no pop and the pointer is held.
- Output: the popped entry is registered into RegWrite* on the same edge, so RegWriteEnable=1 for exactly one cycle per pop. When there is no pop, RegWriteEnable=0 and Addr/Data hold their last values.
- Latency: entry accepted at edge k into an empty system -> earliest pop at edge k+1 -> RegWriteEnable high in the cycle after edge k+1 (2 edges total).
- Throughput: 1 write per cycle aggregate; per channel, 1 write per NUM_CH cycles under full contention.
- Ordering:
  - FIFO order is preserved within a channel.
  - No ordering is guaranteed across channels. Issue logic must use pending_mask to avoid two channels targeting the same register concurrently.
- pending_mask: OR over all valid FIFO entries and the output register when RegWriteEnable=1. It is combinational from registered state; no input-to-output combinational path.
- Simultaneous push and pop on one FIFO: both occur; the count is unchanged.
- Push into an empty FIFO: that entry cannot be popped on the same edge.
- Count and pointer widths: clog2(DEPTH)+1 count bits. Pointers wrap mod DEPTH with no special case.

Optional Feature:
Macro WB_MERGE_FWD_EN.
- Defined: adds ports fwd_addr (in, REG_ADDR_WIDTH), fwd_hit (out, 1) and fwd_data (out, WORD_WIDTH), all combinational.
  - Lookup priority: output register (when RegWriteEnable=1) is the lowest priority.
  - The youngest matching FIFO entry takes precedence; on a tie across channels, the lowest channel index wins.
  - fwd_addr=0 always gives fwd_hit=0, fwd_data=0.
- Undefined: ports absent; no comparators synthesised.

Decomposition:
- Shared package/header wb_pkg: WORD_WIDTH, REG_ADDR_WIDTH and NUM_REGS defaults, the write-entry struct {addr, data}, and the clog2 helper.
- Sub-module wb_chan_fifo: single-channel DEPTH-entry synchronous FIFO with full, empty and count, and an entry-valid vector exposed for pending_mask and forwarding. Instantiated NUM_CH times by generate.

Test Plan:
- Reset release, idle -> RegWriteEnable=0, pending_mask=0, in_ready=2'b11.
- Ch0 write (addr 3, 0xBEEF) at edge 1 -> pending_mask[3]=1 from edge 1. RegWriteEnable=1, Addr=3, Data=0xBEEF in the cycle after edge 2; pending_mask[3]=0 after edge 3.
- Both channels push every cycle for 8 cycles -> outputs alternate ch0,ch1,ch0,...
  - in_ready drops to 0 when a FIFO reaches 4 entries.
  - Per-channel data order is preserved; no entry is lost or duplicated.
- Ch1 writes (addr 0, 0x1234) -> accepted, no RegWriteEnable pulse, pending_mask stays 0.
- Fill ch0 with 3 entries, assert rst for 1 cycle mid-stream -> no writes emitted after reset; in_ready=all ones.
- WB_MERGE_FWD_EN: queue ch0 (addr 5, 0x0001) then ch0 (addr 5, 0x0002); fwd_addr=5 -> fwd_hit=1, fwd_data=0x0002. fwd_addr=0 -> fwd_hit=0.
